// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory-port arbiter: FSM state, requester id,
// and the saturating increment used by the optional ARB_STATS_EN counters.
package mem_arb_pkg;

  typedef enum logic {S_IDLE, S_WAIT} arb_state_t;
  typedef enum logic {REQ_C, REQ_D} req_id_t;

  localparam int MAX_MEM_LAT = 7;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin picker: the requester that did not win last time
// takes a tie; a lone requester always wins. Bit 0 is the core, bit 1 the loader.
module mem_arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last,
  output req_id_t    gnt_id,
  output logic       any
);

  always_comb begin
    any    = |req;
    gnt_id = REQ_C;
    if (req == 2'b11) begin
      gnt_id = (last == REQ_C) ? REQ_D : REQ_C;
    end else if (req[1]) begin
      gnt_id = REQ_D;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single memory port between the core (c_*) and the loader/DMA (d_*),
// one transaction at a time. Define ARB_STATS_EN to add saturating grant/conflict counters.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] m_adr,
  output logic [DW-1:0] m_wd,
  output logic          m_we,
  input  logic [DW-1:0] m_rd
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]   c_cnt,
  output logic [15:0]   d_cnt,
  output logic [15:0]   conflict_cnt
`endif
);

  localparam int       LAT_M1   = (MEM_LAT > 0) ? MEM_LAT - 1 : 0;
  localparam logic [2:0] LAT_INIT = LAT_M1[2:0];

  arb_state_t    state_q, state_d;
  req_id_t       owner_q, owner_d;
  req_id_t       last_q, last_d;
  logic [2:0]    lat_cnt_q, lat_cnt_d;
  logic [AW-1:0] adr_q, adr_d;

  req_id_t       pick;
  logic          any_req;
  logic          win_we;
  logic [AW-1:0] win_adr;
  logic [DW-1:0] win_wd;

  mem_arb_rr2 u_rr2 (
    .req    ({d_req, c_req}),
    .last   (last_q),
    .gnt_id (pick),
    .any    (any_req)
  );

  always_comb begin
    win_we  = (pick == REQ_D) ? d_we    : c_we;
    win_adr = (pick == REQ_D) ? d_addr  : c_addr;
    win_wd  = (pick == REQ_D) ? d_wdata : c_wdata;
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    lat_cnt_d = lat_cnt_q;
    adr_d     = adr_q;
    c_gnt     = 1'b0;
    d_gnt     = 1'b0;
    c_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    m_we      = 1'b0;
    m_adr     = '0;
    m_wd      = '0;
    // rst gates the combinational grant path so nothing is issued while reset is held
    case (state_q)
      S_IDLE: begin
        if (any_req && rst) begin
          m_adr  = win_adr;
          m_wd   = win_wd;
          m_we   = win_we;
          c_gnt  = (pick == REQ_C);
          d_gnt  = (pick == REQ_D);
          last_d = pick;
          if (!win_we) begin
            if (MEM_LAT == 0) begin
              c_rvalid = (pick == REQ_C);
              d_rvalid = (pick == REQ_D);
            end else begin
              state_d   = S_WAIT;
              owner_d   = pick;
              lat_cnt_d = LAT_INIT;
              adr_d     = win_adr;
            end
          end
        end
      end
      S_WAIT: begin
        m_adr = adr_q;
        if (lat_cnt_q == 3'd0) begin
          c_rvalid = (owner_q == REQ_C);
          d_rvalid = (owner_q == REQ_D);
          state_d  = S_IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q - 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign c_rdata = c_rvalid ? m_rd : '0;
  assign d_rdata = d_rvalid ? m_rd : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      owner_q   <= REQ_C;
      last_q    <= REQ_D;
      lat_cnt_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

  // Held read address is only observed in S_WAIT, so it needs no reset
  always_ff @(posedge clk) begin
    adr_q <= adr_d;
  end

`ifdef ARB_STATS_EN
  logic [15:0] c_cnt_q, c_cnt_d;
  logic [15:0] d_cnt_q, d_cnt_d;
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    c_cnt_d        = c_gnt ? sat_inc16(c_cnt_q) : c_cnt_q;
    d_cnt_d        = d_gnt ? sat_inc16(d_cnt_q) : d_cnt_q;
    conflict_cnt_d = (c_req && d_req) ? sat_inc16(conflict_cnt_q) : conflict_cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_cnt_q        <= 16'd0;
      d_cnt_q        <= 16'd0;
      conflict_cnt_q <= 16'd0;
    end else begin
      c_cnt_q        <= c_cnt_d;
      d_cnt_q        <= d_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign c_cnt        = c_cnt_q;
  assign d_cnt        = d_cnt_q;
  assign conflict_cnt = conflict_cnt_q;
`endif

`ifndef SYNTHESIS
  c_req_held: assert property (@(posedge clk) disable iff (!rst) (c_req && !c_gnt) |=> c_req);
  d_req_held: assert property (@(posedge clk) disable iff (!rst) (d_req && !d_gnt) |=> d_req);
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: three instances (MEM_LAT 0, 2, 3) driven one at a time
// against a timestamp-based transaction model. Honours ARB_STATS_EN.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]       c_req, c_we, d_req, d_we;
  logic [2:0]       c_gnt, c_rvalid, d_gnt, d_rvalid, m_we;
  logic [2:0][31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic [2:0][31:0] c_rdata, d_rdata, m_adr, m_wd, m_rd;
`ifdef ARB_STATS_EN
  logic [2:0][15:0] c_cnt, d_cnt, conflict_cnt;
`endif

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] init_word(input int u, input int i);
    return 32'hA500_0000 ^ (32'(u) << 20) ^ (32'(i) * 32'h0001_0101);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
    logic [31:0] mem [256];
    logic [31:0] pipe [4];

    mem_bus_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) dut (
      .clk      (clk),
      .rst      (rst),
      .c_req    (c_req[g]),
      .c_we     (c_we[g]),
      .c_addr   (c_addr[g]),
      .c_wdata  (c_wdata[g]),
      .c_gnt    (c_gnt[g]),
      .c_rvalid (c_rvalid[g]),
      .c_rdata  (c_rdata[g]),
      .d_req    (d_req[g]),
      .d_we     (d_we[g]),
      .d_addr   (d_addr[g]),
      .d_wdata  (d_wdata[g]),
      .d_gnt    (d_gnt[g]),
      .d_rvalid (d_rvalid[g]),
      .d_rdata  (d_rdata[g]),
      .m_adr    (m_adr[g]),
      .m_wd     (m_wd[g]),
      .m_we     (m_we[g]),
      .m_rd     (m_rd[g])
`ifdef ARB_STATS_EN
      ,
      .c_cnt        (c_cnt[g]),
      .d_cnt        (d_cnt[g]),
      .conflict_cnt (conflict_cnt[g])
`endif
    );

    initial begin
      for (int i = 0; i < 256; i++) mem[i] = init_word(g, i);
      for (int i = 0; i < 4; i++) pipe[i] = 32'h0;
    end

    // memory model: data for the presented address appears LAT cycles later
    always @(posedge clk) begin
      for (int i = 3; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = mem[m_adr[g][9:2]];
      if (m_we[g]) mem[m_adr[g][9:2]] = m_wd[g];
    end

    if (LAT == 0) begin : g_comb
      assign m_rd[g] = mem[m_adr[g][9:2]];
    end else begin : g_pipe
      assign m_rd[g] = pipe[LAT-1];
    end
  end

  // reference model state
  int          lats [3] = '{0, 2, 3};
  logic [31:0] rmem [3][256];
  int          k, tcyc, free_at, rv_at;
  bit          rv_d, last_is_d, eg_c, eg_d;
  logic [31:0] rv_data, hold_adr;
  int          mc_cnt, md_cnt, mconf;

  bit          s_creq, s_cwe, s_dreq, s_dwe;
  logic [31:0] s_caddr, s_cwd, s_daddr, s_dwd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic set_c(input bit rq, input bit we, input logic [31:0] a, input logic [31:0] wd);
    s_creq = rq; s_cwe = we; s_caddr = a; s_cwd = wd;
  endtask

  task automatic set_d(input bit rq, input bit we, input logic [31:0] a, input logic [31:0] wd);
    s_dreq = rq; s_dwe = we; s_daddr = a; s_dwd = wd;
  endtask

  task automatic apply();
    c_req[k] = s_creq; c_we[k] = s_cwe; c_addr[k] = s_caddr; c_wdata[k] = s_cwd;
    d_req[k] = s_dreq; d_we[k] = s_dwe; d_addr[k] = s_daddr; d_wdata[k] = s_dwd;
  endtask

  task automatic model_reset();
    free_at = tcyc; rv_at = -1; last_is_d = 1'b1;
    mc_cnt = 0; md_cnt = 0; mconf = 0;
  endtask

  task automatic clear_all();
    c_req = '0; c_we = '0; d_req = '0; d_we = '0;
    c_addr = '0; c_wdata = '0; d_addr = '0; d_wdata = '0;
    set_c(0, 0, 0, 0);
    set_d(0, 0, 0, 0);
  endtask

  // one clock of the active instance: drive, sample mid-cycle, compare, advance model
  task automatic step();
    bit          win_d, e_cg, e_dg, e_cv, e_dv, e_we;
    logic [31:0] e_adr, e_wd, e_cr, e_dr, w_adr;
    @(negedge clk);
    apply();
    #1;
    e_cg = 0; e_dg = 0; e_cv = 0; e_dv = 0; e_we = 0;
    e_adr = 0; e_wd = 0; e_cr = 0; e_dr = 0;
    if (tcyc >= free_at && (s_creq || s_dreq)) begin
      win_d = (s_creq && s_dreq) ? !last_is_d : s_dreq;
      e_cg  = !win_d;
      e_dg  = win_d;
      w_adr = win_d ? s_daddr : s_caddr;
      e_adr = w_adr;
      e_we  = win_d ? s_dwe : s_cwe;
      e_wd  = win_d ? s_dwd : s_cwd;
      last_is_d = win_d;
      if (e_we) begin
        rmem[k][w_adr[9:2]] = e_wd;
        free_at = tcyc + 1;
      end else begin
        rv_at    = tcyc + lats[k];
        rv_d     = win_d;
        rv_data  = rmem[k][w_adr[9:2]];
        hold_adr = w_adr;
        free_at  = tcyc + lats[k] + 1;
      end
    end else if (tcyc < free_at) begin
      e_adr = hold_adr;
    end
    if (rv_at == tcyc) begin
      if (rv_d) begin e_dv = 1; e_dr = rv_data; end
      else begin e_cv = 1; e_cr = rv_data; end
    end
    chk("c_gnt", c_gnt[k], e_cg);
    chk("d_gnt", d_gnt[k], e_dg);
    chk("m_we", m_we[k], e_we);
    chk("m_adr", m_adr[k], e_adr);
    if (e_we) chk("m_wd", m_wd[k], e_wd);
    chk("c_rvalid", c_rvalid[k], e_cv);
    chk("d_rvalid", d_rvalid[k], e_dv);
    chk("c_rdata", c_rdata[k], e_cr);
    chk("d_rdata", d_rdata[k], e_dr);
`ifdef ARB_STATS_EN
    chk("c_cnt", c_cnt[k], mc_cnt);
    chk("d_cnt", d_cnt[k], md_cnt);
    chk("conflict_cnt", conflict_cnt[k], mconf);
    if (e_cg && mc_cnt < 65535) mc_cnt++;
    if (e_dg && md_cnt < 65535) md_cnt++;
    if (s_creq && s_dreq && mconf < 65535) mconf++;
`endif
    eg_c = e_cg;
    eg_d = e_dg;
    tcyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_all();
    model_reset();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic rand_req_c();
    logic [31:0] a;
    a = $urandom() & 32'hFFFF_FC3C;
    if ($urandom_range(0, 99) < 60) set_c(1, 1'($urandom_range(0, 1)), a, $urandom());
    else set_c(0, 0, 0, 0);
  endtask

  task automatic rand_req_d();
    logic [31:0] a;
    a = $urandom() & 32'hFFFF_FC3C;
    if ($urandom_range(0, 99) < 60) set_d(1, 1'($urandom_range(0, 1)), a, $urandom());
    else set_d(0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b0;
    tcyc = 0;
    k = 0;
    for (int u = 0; u < 3; u++)
      for (int i = 0; i < 256; i++) rmem[u][i] = init_word(u, i);
    clear_all();
    model_reset();

    // reset held with both requests up: nothing may be granted or returned
    set_c(1, 1, 32'h40, 32'hDEADBEEF);
    set_d(1, 1, 32'h80, 32'h1111_1111);
    apply();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_c_gnt", c_gnt[0], 0);
    chk("rst_d_gnt", d_gnt[0], 0);
    chk("rst_m_we", m_we[0], 0);
    chk("rst_m_adr", m_adr[0], 0);
    chk("rst_c_rdata", c_rdata[0], 0);
    chk("rst_d_rdata", d_rdata[0], 0);
    @(posedge clk);
    #1 rst = 1'b1;

    // core wins the first tie, its write goes out in the grant cycle
    step();
    chk("first_c_gnt", c_gnt[0], 1);
    chk("wr_m_we", m_we[0], 1);
    chk("wr_m_adr", m_adr[0], 32'h40);
    set_c(0, 0, 0, 0);
    step();
    chk("then_d_gnt", d_gnt[0], 1);
    set_d(0, 0, 0, 0);
    set_c(1, 0, 32'h40, 0);
    step();
    chk("lat0_c_rvalid", c_rvalid[0], 1);
    chk("lat0_readback", c_rdata[0], 32'hDEADBEEF);
    set_c(0, 0, 0, 0);
    step();

    // MEM_LAT=2, simultaneous reads
    do_reset();
    k = 1;
    set_c(1, 0, 32'h10, 0);
    set_d(1, 0, 32'h20, 0);
    step();
    chk("t0_c_gnt", c_gnt[1], 1);
    chk("t0_m_adr", m_adr[1], 32'h10);
    set_c(0, 0, 0, 0);
    step();
    chk("t1_m_adr", m_adr[1], 32'h10);
    chk("t1_d_gnt", d_gnt[1], 0);
    step();
    chk("t2_c_rvalid", c_rvalid[1], 1);
    chk("t2_m_adr", m_adr[1], 32'h10);
    chk("t2_c_rdata", c_rdata[1], init_word(1, 4));
    step();
    chk("t3_d_gnt", d_gnt[1], 1);
    set_d(0, 0, 0, 0);
    step();
    step();
    chk("t5_d_rvalid", d_rvalid[1], 1);
    chk("t5_d_rdata", d_rdata[1], init_word(1, 8));

    // continuous contention alternates
    do_reset();
    k = 0;
    set_c(1, 1, 32'h200, 32'hC000_0000);
    set_d(1, 1, 32'h300, 32'hD000_0000);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("alt_c_gnt", c_gnt[0], 32'((i % 2) == 0));
      chk("alt_d_gnt", d_gnt[0], 32'((i % 2) == 1));
      if (i < 7) begin
        if (eg_c) set_c(1, 1, 32'h200 + 32'(i) * 4, 32'hC000_0000 + 32'(i));
        if (eg_d) set_d(1, 1, 32'h300 + 32'(i) * 4, 32'hD000_0000 + 32'(i));
      end
    end
    set_d(0, 0, 0, 0);
    step();
`ifdef ARB_STATS_EN
    chk("alt_c_cnt", c_cnt[0], 4);
    chk("alt_d_cnt", d_cnt[0], 4);
`endif
    set_c(0, 0, 0, 0);
    step();

    // reset during the wait of a loader read drops it
    do_reset();
    k = 2;
    set_d(1, 0, 32'h30, 0);
    step();
    chk("w_d_gnt", d_gnt[2], 1);
    set_d(0, 0, 0, 0);
    step();
    #2 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("rst_wait_d_rvalid", d_rvalid[2], 0);
      chk("rst_wait_d_rdata", d_rdata[2], 0);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    set_c(1, 0, 32'h44, 0);
    step();
    chk("post_rst_c_gnt", c_gnt[2], 1);
    set_c(0, 0, 0, 0);
    repeat (5) step();

    // randomized traffic on each latency
    for (int u = 0; u < 3; u++) begin
      do_reset();
      k = u;
      for (int n = 0; n < 400; n++) begin
        if (!s_creq) rand_req_c();
        if (!s_dreq) rand_req_d();
        step();
        if (eg_c) set_c(0, 0, 0, 0);
        if (eg_d) set_d(0, 0, 0, 0);
      end
      for (int n = 0; n < 16; n++) begin
        step();
        if (eg_c) set_c(0, 0, 0, 0);
        if (eg_d) set_d(0, 0, 0, 0);
      end
      chk("drained_c_req", 32'(s_creq), 0);
      chk("drained_d_req", 32'(s_dreq), 0);
    end

`ifdef ARB_STATS_EN
    // grant counter saturation
    do_reset();
    k = 0;
    set_c(1, 1, 32'h3FC, 32'h5A5A_5A5A);
    @(negedge clk);
    apply();
    repeat (70000) @(negedge clk);
    #1;
    chk("c_cnt_sat", c_cnt[0], 16'hFFFF);
    set_c(0, 0, 0, 0);
    apply();
    @(negedge clk);
    #1;
    chk("c_cnt_sat_hold", c_cnt[0], 16'hFFFF);
    chk("d_cnt_zero", d_cnt[0], 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
